// File: rtl/riscv_mem_arbiter_pkg.sv
// Shared constants for the unified-memory arbiter: FSM state encoding,
// requester grant IDs and the read-latency counter width.
package riscv_mem_arbiter_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    ARB_GNT_IF = 1'b0,
    ARB_GNT_DM = 1'b1
  } arb_gnt_e;

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter; slave is the arbiter's view,
// master is the view of the requesters plus memory model.
interface riscv_mem_arbiter_if #(
  parameter int XLEN = 32
);
  logic            i_if_req;
  logic [XLEN-1:0] i_if_addr;
  logic            o_if_ack;
  logic [XLEN-1:0] o_if_rd_data;
  logic            i_dm_req;
  logic            i_dm_wr_en;
  logic [3:0]      i_dm_strb;
  logic [XLEN-1:0] i_dm_addr;
  logic [XLEN-1:0] i_dm_wr_data;
  logic            o_dm_ack;
  logic [XLEN-1:0] o_dm_rd_data;
  logic            o_mem_en;
  logic            o_mem_wr_en;
  logic [3:0]      o_mem_strb;
  logic [XLEN-1:0] o_mem_addr;
  logic [XLEN-1:0] o_mem_wr_data;
  logic [XLEN-1:0] i_mem_rd_data;
  logic            o_arb_busy;

  modport slave (
    input  i_if_req, i_if_addr, i_dm_req, i_dm_wr_en, i_dm_strb, i_dm_addr,
           i_dm_wr_data, i_mem_rd_data,
    output o_if_ack, o_if_rd_data, o_dm_ack, o_dm_rd_data, o_mem_en,
           o_mem_wr_en, o_mem_strb, o_mem_addr, o_mem_wr_data, o_arb_busy
  );

  modport master (
    output i_if_req, i_if_addr, i_dm_req, i_dm_wr_en, i_dm_strb, i_dm_addr,
           i_dm_wr_data, i_mem_rd_data,
    input  o_if_ack, o_if_rd_data, o_dm_ack, o_dm_rd_data, o_mem_en,
           o_mem_wr_en, o_mem_strb, o_mem_addr, o_mem_wr_data, o_arb_busy
  );
endinterface

// File: rtl/riscv_arb_grant.sv
// Combinational grant picker for the memory arbiter. Ties go to DM unless
// RISCV_ARB_RR_EN is defined, in which case the requester not served last wins.
module riscv_arb_grant
  import riscv_mem_arbiter_pkg::*;
(
  input  logic     if_req,
  input  logic     dm_req,
  input  arb_gnt_e last_gnt,
  output logic     gnt_vld,
  output arb_gnt_e gnt_id
);

`ifdef RISCV_ARB_RR_EN
  logic tie_to_if;
  assign tie_to_if = (last_gnt == ARB_GNT_DM);
`else
  logic tie_to_if;
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt;
  assign tie_to_if       = 1'b0;
`endif

  always_comb begin
    gnt_vld = if_req | dm_req;
    gnt_id  = ARB_GNT_DM;
    if (if_req && (!dm_req || tie_to_if)) gnt_id = ARB_GNT_IF;
  end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access:
// IDLE -> ISSUE -> (WAIT) -> RESP. Build option RISCV_ARB_RR_EN selects round-robin ties.
module riscv_mem_arbiter
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MEM_LAT = 1
) (
  input logic                i_clk,
  input logic                i_rst,
  riscv_mem_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

  arb_state_e      state;
  arb_gnt_e        gnt_q;
  arb_gnt_e        last_gnt;
  arb_gnt_e        pick_id;
  logic            pick_vld;
  logic            pick_dm;
  logic [XLEN-1:0] pick_addr;
  logic [CNT_W-1:0] lat_cnt;

  riscv_arb_grant u_grant (
    .if_req   (bus.i_if_req),
    .dm_req   (bus.i_dm_req),
    .last_gnt (last_gnt),
    .gnt_vld  (pick_vld),
    .gnt_id   (pick_id)
  );

  assign pick_dm   = (pick_id == ARB_GNT_DM);
  assign pick_addr = pick_dm ? bus.i_dm_addr : bus.i_if_addr;

`ifdef RISCV_ARB_RR_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                              last_gnt <= ARB_GNT_DM;
    else if (state == ARB_IDLE && pick_vld) last_gnt <= pick_id;
  end
`else
  assign last_gnt = ARB_GNT_DM;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state             <= ARB_IDLE;
      gnt_q             <= ARB_GNT_DM;
      lat_cnt           <= '0;
      bus.o_if_ack      <= 1'b0;
      bus.o_if_rd_data  <= '0;
      bus.o_dm_ack      <= 1'b0;
      bus.o_dm_rd_data  <= '0;
      bus.o_mem_en      <= 1'b0;
      bus.o_mem_wr_en   <= 1'b0;
      bus.o_mem_strb    <= '0;
      bus.o_mem_addr    <= '0;
      bus.o_mem_wr_data <= '0;
      bus.o_arb_busy    <= 1'b0;
    end else begin
      bus.o_if_ack <= 1'b0;
      bus.o_dm_ack <= 1'b0;
      case (state)
        ARB_IDLE: begin
          // Payload is latched here so requester changes after ISSUE are ignored
          if (pick_vld) begin
            state             <= ARB_ISSUE;
            gnt_q             <= pick_id;
            bus.o_arb_busy    <= 1'b1;
            bus.o_mem_en      <= 1'b1;
            bus.o_mem_addr    <= pick_addr;
            bus.o_mem_wr_en   <= pick_dm & bus.i_dm_wr_en;
            bus.o_mem_strb    <= pick_dm ? bus.i_dm_strb : 4'h0;
            bus.o_mem_wr_data <= pick_dm ? bus.i_dm_wr_data : '0;
          end
        end
        ARB_ISSUE: begin
          bus.o_mem_en    <= 1'b0;
          bus.o_mem_wr_en <= 1'b0;
          lat_cnt         <= LAT_LOAD;
          if (bus.o_mem_wr_en) begin
            state        <= ARB_RESP;
            bus.o_dm_ack <= 1'b1;
          end else begin
            state <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (lat_cnt == '0) begin
            state <= ARB_RESP;
            if (gnt_q == ARB_GNT_DM) begin
              bus.o_dm_ack     <= 1'b1;
              bus.o_dm_rd_data <= bus.i_mem_rd_data;
            end else begin
              bus.o_if_ack     <= 1'b1;
              bus.o_if_rd_data <= bus.i_mem_rd_data;
            end
          end else begin
            lat_cnt <= lat_cnt - CNT_W'(1);
          end
        end
        ARB_RESP: begin
          state          <= ARB_IDLE;
          bus.o_arb_busy <= 1'b0;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench for riscv_mem_arbiter: vector table, hand-written corner
// sequences (arbitration, long latency, mid-WAIT reset) and a randomized run.
module tb_riscv_mem_arbiter;

  localparam int XLEN = 32;
  localparam int LAT1 = 1;
  localparam int LAT4 = 4;
`ifdef RISCV_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  riscv_mem_arbiter_if #(.XLEN(XLEN)) bus1 ();
  riscv_mem_arbiter_if #(.XLEN(XLEN)) bus4 ();

  riscv_mem_arbiter #(.XLEN(XLEN), .MEM_LAT(LAT1)) u_dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1));
  riscv_mem_arbiter #(.XLEN(XLEN), .MEM_LAT(LAT4)) u_dut4 (.i_clk(clk), .i_rst(rst), .bus(bus4));

  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory models: data valid only exactly MEM_LAT cycles after the enable cycle, junk otherwise
  int pend1 = 0, pend4 = 0;
  logic [31:0] paddr1, paddr4;
  always @(negedge clk) begin
    bus1.i_mem_rd_data = $urandom;
    if (rst) pend1 = 0;
    else if (bus1.o_mem_en && !bus1.o_mem_wr_en) begin pend1 = LAT1; paddr1 = bus1.o_mem_addr; end
    else if (pend1 > 0) begin
      pend1--;
      if (pend1 == 0) bus1.i_mem_rd_data = mem_word(paddr1);
    end
  end
  always @(negedge clk) begin
    bus4.i_mem_rd_data = $urandom;
    if (rst) pend4 = 0;
    else if (bus4.o_mem_en && !bus4.o_mem_wr_en) begin pend4 = LAT4; paddr4 = bus4.o_mem_addr; end
    else if (pend4 > 0) begin
      pend4--;
      if (pend4 == 0) bus4.i_mem_rd_data = mem_word(paddr4);
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, " b1 ctl"}, {bus1.o_if_ack, bus1.o_dm_ack, bus1.o_mem_en, bus1.o_mem_wr_en, bus1.o_arb_busy, bus1.o_mem_strb}, 0);
    chk({tag, " b1 if_rd"}, bus1.o_if_rd_data, 0);
    chk({tag, " b1 dm_rd"}, bus1.o_dm_rd_data, 0);
    chk({tag, " b1 addr"}, bus1.o_mem_addr, 0);
    chk({tag, " b1 wdata"}, bus1.o_mem_wr_data, 0);
    chk({tag, " b4 ctl"}, {bus4.o_if_ack, bus4.o_dm_ack, bus4.o_mem_en, bus4.o_mem_wr_en, bus4.o_arb_busy, bus4.o_mem_strb}, 0);
    chk({tag, " b4 if_rd"}, bus4.o_if_rd_data, 0);
    chk({tag, " b4 dm_rd"}, bus4.o_dm_rd_data, 0);
    chk({tag, " b4 addr"}, bus4.o_mem_addr, 0);
    chk({tag, " b4 wdata"}, bus4.o_mem_wr_data, 0);
  endtask

  typedef struct {
    bit          dm;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          ack_cyc;
    logic [31:0] exp_rd;
    logic [31:0] exp_other;
  } vec_t;
  vec_t vecs[6];

  // Random-run state
  bit          prev_if, prev_dm, last_dm, g_dm, ack_dm, ack_wr, exp_en;
  int          busy_until, ack_cyc, if_gap, dm_gap, n_arb;
  logic [31:0] ack_addr, m_if_rd, m_dm_rd;
  int          got[4];

  task automatic new_if_txn();
    bus1.i_if_req  = 1'b1;
    bus1.i_if_addr = $urandom & 32'hFFFF_FFFC;
  endtask

  task automatic new_dm_txn();
    bus1.i_dm_req     = 1'b1;
    bus1.i_dm_wr_en   = $urandom_range(0, 1) == 1;
    bus1.i_dm_strb    = 4'($urandom_range(1, 15));
    bus1.i_dm_addr    = $urandom & 32'hFFFF_FFFC;
    bus1.i_dm_wr_data = $urandom;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus1.i_if_req = 0; bus1.i_if_addr = 0; bus1.i_dm_req = 0; bus1.i_dm_wr_en = 0;
    bus1.i_dm_strb = 0; bus1.i_dm_addr = 0; bus1.i_dm_wr_data = 0;
    bus4.i_if_req = 0; bus4.i_if_addr = 0; bus4.i_dm_req = 0; bus4.i_dm_wr_en = 0;
    bus4.i_dm_strb = 0; bus4.i_dm_addr = 0; bus4.i_dm_wr_data = 0;

    vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 3, 32'h0050_0093, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'b0011, 2, 32'h0, 32'h0050_0093};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_3004, 32'h0, 4'h0, 3, 32'h3004_CFFB, 32'h0050_0093};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_4008, 32'h1234_5678, 4'b1111, 2, 32'h3004_CFFB, 32'h0050_0093};
    vecs[4] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 3, 32'hFFFC_0003, 32'h3004_CFFB};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 3, 32'h0040_FFBF, 32'hFFFC_0003};

    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // Single transactions, one per vector, starting in the first cycle after reset release
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].dm) begin
        bus1.i_dm_req = 1'b1; bus1.i_dm_wr_en = vecs[i].wr; bus1.i_dm_strb = vecs[i].strb;
        bus1.i_dm_addr = vecs[i].addr; bus1.i_dm_wr_data = vecs[i].wdata;
      end else begin
        bus1.i_if_req = 1'b1; bus1.i_if_addr = vecs[i].addr;
      end
      for (int c = 1; c <= vecs[i].ack_cyc + 1; c++) begin
        tick();
        chk($sformatf("v%0d c%0d mem_en", i, c), bus1.o_mem_en, c == 1);
        chk($sformatf("v%0d c%0d wr_en_outside_en", i, c), bus1.o_mem_wr_en & ~bus1.o_mem_en, 0);
        chk($sformatf("v%0d c%0d busy", i, c), bus1.o_arb_busy, c <= vecs[i].ack_cyc);
        chk($sformatf("v%0d c%0d if_ack", i, c), bus1.o_if_ack, !vecs[i].dm && c == vecs[i].ack_cyc);
        chk($sformatf("v%0d c%0d dm_ack", i, c), bus1.o_dm_ack, vecs[i].dm && c == vecs[i].ack_cyc);
        if (c == 1) begin
          chk($sformatf("v%0d addr", i), bus1.o_mem_addr, vecs[i].addr);
          chk($sformatf("v%0d wr_en", i), bus1.o_mem_wr_en, vecs[i].wr);
          if (vecs[i].wr) begin
            chk($sformatf("v%0d strb", i), bus1.o_mem_strb, vecs[i].strb);
            chk($sformatf("v%0d wdata", i), bus1.o_mem_wr_data, vecs[i].wdata);
          end
        end
        if (c == vecs[i].ack_cyc) begin
          chk($sformatf("v%0d own rd", i), vecs[i].dm ? bus1.o_dm_rd_data : bus1.o_if_rd_data, vecs[i].exp_rd);
          chk($sformatf("v%0d other rd", i), vecs[i].dm ? bus1.o_if_rd_data : bus1.o_dm_rd_data, vecs[i].exp_other);
          bus1.i_if_req = 1'b0;
          bus1.i_dm_req = 1'b0;
        end
      end
    end

    // Both requesters hold back-to-back reads; record who gets served
    for (int k = 0; k < 4; k++) got[k] = 2;
    n_arb = 0;
    bus1.i_if_req = 1'b1; bus1.i_if_addr = 32'h0000_1000;
    bus1.i_dm_req = 1'b1; bus1.i_dm_wr_en = 1'b0; bus1.i_dm_addr = 32'h0000_8000;
    for (int c = 1; c <= 40 && n_arb < 4; c++) begin
      tick();
      if (bus1.o_if_ack) begin
        chk($sformatf("arb%0d if rd", n_arb), bus1.o_if_rd_data, mem_word(bus1.i_if_addr));
        got[n_arb] = 0; n_arb++;
        bus1.i_if_addr = bus1.i_if_addr + 32'd4;
      end
      if (bus1.o_dm_ack) begin
        chk($sformatf("arb%0d dm rd", n_arb), bus1.o_dm_rd_data, mem_word(bus1.i_dm_addr));
        got[n_arb] = 1; n_arb++;
        bus1.i_dm_addr = bus1.i_dm_addr + 32'd4;
      end
    end
    bus1.i_if_req = 1'b0;
    bus1.i_dm_req = 1'b0;
    chk("arb ack count", n_arb, 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("arb grant %0d (0=IF 1=DM)", k), got[k], RR ? k % 2 : 1);
    tick(); tick();

    // MEM_LAT=4 DM read; payload altered after ISSUE must not reach the port
    bus4.i_dm_req = 1'b1; bus4.i_dm_wr_en = 1'b0; bus4.i_dm_addr = 32'h0000_5000;
    for (int c = 1; c <= 7; c++) begin
      tick();
      chk($sformatf("lat4 c%0d mem_en", c), bus4.o_mem_en, c == 1);
      chk($sformatf("lat4 c%0d dm_ack", c), bus4.o_dm_ack, c == 6);
      if (c <= 5) begin
        chk($sformatf("lat4 c%0d addr", c), bus4.o_mem_addr, 32'h0000_5000);
        chk($sformatf("lat4 c%0d busy", c), bus4.o_arb_busy, 1);
      end
      if (c == 1) bus4.i_dm_addr = 32'hAAAA_0000;
      if (c == 6) begin
        chk("lat4 dm rd", bus4.o_dm_rd_data, 32'h5000_AFFF);
        bus4.i_dm_req = 1'b0;
      end
      if (c == 7) chk("lat4 busy after", bus4.o_arb_busy, 0);
    end

    // Reset pulse while in WAIT; the held request restarts after release
    bus4.i_dm_addr = 32'h0000_6000; bus4.i_dm_req = 1'b1;
    repeat (3) tick();
    chk("rst pre busy", bus4.o_arb_busy, 1);
    chk("rst pre addr", bus4.o_mem_addr, 32'h0000_6000);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("rst mid-wait");
    tick();
    chk("rst held ack", bus4.o_dm_ack, 0);
    rst = 1'b0;
    tick();
    chk("rst restart en", bus4.o_mem_en, 1);
    chk("rst restart addr", bus4.o_mem_addr, 32'h0000_6000);
    for (int c = 2; c <= 7; c++) begin
      tick();
      chk($sformatf("rst c%0d dm_ack", c), bus4.o_dm_ack, c == 6);
      if (c == 6) begin
        chk("rst dm rd", bus4.o_dm_rd_data, 32'h6000_9FFF);
        bus4.i_dm_req = 1'b0;
      end
      if (c == 7) chk("rst busy after", bus4.o_arb_busy, 0);
    end

    // Randomized traffic against a transaction-level reference model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    prev_if = 0; prev_dm = 0; last_dm = 1; busy_until = -1; ack_cyc = -1;
    ack_dm = 0; ack_wr = 0; ack_addr = 0; m_if_rd = 0; m_dm_rd = 0;
    if_gap = $urandom_range(0, 3); dm_gap = $urandom_range(0, 3);
    for (int t = 0; t < 600; t++) begin
      tick();
      exp_en = (t - 1 > busy_until) && (prev_if || prev_dm);
      chk($sformatf("rnd t%0d mem_en", t), bus1.o_mem_en, exp_en);
      chk($sformatf("rnd t%0d wr_en_outside_en", t), bus1.o_mem_wr_en & ~bus1.o_mem_en, 0);
      if (exp_en) begin
        if (prev_if && prev_dm) g_dm = RR ? !last_dm : 1'b1;
        else                    g_dm = prev_dm;
        last_dm  = g_dm;
        ack_dm   = g_dm;
        ack_wr   = g_dm && bus1.i_dm_wr_en;
        ack_addr = g_dm ? bus1.i_dm_addr : bus1.i_if_addr;
        chk($sformatf("rnd t%0d addr", t), bus1.o_mem_addr, ack_addr);
        chk($sformatf("rnd t%0d wr_en", t), bus1.o_mem_wr_en, ack_wr);
        if (ack_wr) begin
          chk($sformatf("rnd t%0d strb", t), bus1.o_mem_strb, bus1.i_dm_strb);
          chk($sformatf("rnd t%0d wdata", t), bus1.o_mem_wr_data, bus1.i_dm_wr_data);
        end
        ack_cyc    = t + (ack_wr ? 1 : LAT1 + 1);
        busy_until = ack_cyc;
      end
      chk($sformatf("rnd t%0d if_ack", t), bus1.o_if_ack, t == ack_cyc && !ack_dm);
      chk($sformatf("rnd t%0d dm_ack", t), bus1.o_dm_ack, t == ack_cyc && ack_dm);
      if (t == ack_cyc) begin
        if (!ack_wr) begin
          if (ack_dm) m_dm_rd = mem_word(ack_addr);
          else        m_if_rd = mem_word(ack_addr);
        end
        if (ack_dm) begin
          if ($urandom_range(0, 1) == 1) new_dm_txn();
          else begin bus1.i_dm_req = 1'b0; dm_gap = $urandom_range(1, 3); end
        end else begin
          if ($urandom_range(0, 1) == 1) new_if_txn();
          else begin bus1.i_if_req = 1'b0; if_gap = $urandom_range(1, 3); end
        end
      end
      chk($sformatf("rnd t%0d if_rd", t), bus1.o_if_rd_data, m_if_rd);
      chk($sformatf("rnd t%0d dm_rd", t), bus1.o_dm_rd_data, m_dm_rd);
      if (!bus1.i_if_req) begin
        if (if_gap == 0) new_if_txn(); else if_gap--;
      end
      if (!bus1.i_dm_req) begin
        if (dm_gap == 0) new_dm_txn(); else dm_gap--;
      end
      prev_if = bus1.i_if_req;
      prev_dm = bus1.i_dm_req;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
